// File: rtl/cpack_match_engine.sv
// C-Pack stage-1 matcher: two-stage pipeline that picks the shortest code per word
// and updates a FIFO-replacement dictionary in the same stage as the compare.
module cpack_match_engine #(
  parameter int WIDTH  = 32,
  parameter int WORDS  = 16,
  parameter int IDX_W  = $clog2(WORDS),
  parameter int CODE_W = WIDTH + 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [WIDTH-1:0]  i_word,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [2:0]        o_pattern,
  output logic [CODE_W-1:0] o_code,
  output logic [5:0]        o_len,
  output logic [IDX_W:0]    o_dict_count
);

  localparam int HALF = WIDTH / 2;
  localparam logic [IDX_W:0] FULL = (IDX_W + 1)'(WORDS);

  typedef enum logic [2:0] {
    PAT_ZZZZ = 3'd0,
    PAT_MMMM = 3'd1,
    PAT_ZZZX = 3'd2,
    PAT_MMMX = 3'd3,
    PAT_MMXX = 3'd4,
    PAT_XXXX = 3'd5
  } pattern_t;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_word;
  logic             adv;

  logic [WIDTH-1:0] dict [WORDS];
  logic [WORDS-1:0] valid;
  logic [IDX_W-1:0] wr_ptr;

  logic             hit_full, hit_byte, hit_half;
  logic [IDX_W-1:0] idx_full, idx_byte, idx_half;
  pattern_t         pat;
  logic [CODE_W-1:0] code;
  logic [5:0]       len;
  logic             push;
  logic             push_en;

  assign adv     = ~o_valid | i_ready;
  assign o_ready = ~s1_valid | adv;
  assign push_en = adv & s1_valid & push & ~i_flush;

  // First hit in ascending index order is kept, so the lowest matching index wins.
  always_comb begin
    hit_full = 1'b0;
    hit_byte = 1'b0;
    hit_half = 1'b0;
    idx_full = '0;
    idx_byte = '0;
    idx_half = '0;
    for (int unsigned i = 0; i < WORDS; i++) begin
      if (valid[i]) begin
        if (!hit_full && dict[i] == s1_word) begin
          hit_full = 1'b1;
          idx_full = IDX_W'(i);
        end
        if (!hit_byte && dict[i][WIDTH-1:8] == s1_word[WIDTH-1:8]) begin
          hit_byte = 1'b1;
          idx_byte = IDX_W'(i);
        end
        if (!hit_half && dict[i][WIDTH-1:HALF] == s1_word[WIDTH-1:HALF]) begin
          hit_half = 1'b1;
          idx_half = IDX_W'(i);
        end
      end
    end
  end

  always_comb begin
    pat  = PAT_XXXX;
    code = CODE_W'({2'b01, s1_word});
    len  = 6'(2 + WIDTH);
    push = 1'b0;
    if (s1_word == '0) begin
      pat  = PAT_ZZZZ;
      code = '0;
      len  = 6'd2;
    end else if (hit_full) begin
      pat  = PAT_MMMM;
      code = CODE_W'({2'b10, idx_full});
      len  = 6'(2 + IDX_W);
    end else if (s1_word[WIDTH-1:8] == '0) begin
      pat  = PAT_ZZZX;
      code = CODE_W'({4'b1101, s1_word[7:0]});
      len  = 6'd12;
    end else if (hit_byte) begin
      pat  = PAT_MMMX;
      code = CODE_W'({4'b1110, idx_byte, s1_word[7:0]});
      len  = 6'(12 + IDX_W);
      push = 1'b1;
    end else if (hit_half) begin
      pat  = PAT_MMXX;
      code = CODE_W'({4'b1100, idx_half, s1_word[HALF-1:0]});
      len  = 6'(4 + IDX_W + HALF);
      push = 1'b1;
    end else begin
      push = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid <= 1'b0;
      s1_word  <= '0;
    end else if (i_valid && o_ready) begin
      s1_valid <= 1'b1;
      s1_word  <= i_word;
    end else if (adv) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid   <= 1'b0;
      o_pattern <= '0;
      o_code    <= '0;
      o_len     <= '0;
    end else if (adv) begin
      o_valid <= s1_valid;
      if (s1_valid) begin
        o_pattern <= pat;
        o_code    <= code;
        o_len     <= len;
      end
    end
  end

  // Flush wins over the push of a word encoded on the same edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid        <= '0;
      wr_ptr       <= '0;
      o_dict_count <= '0;
    end else if (i_flush) begin
      valid        <= '0;
      wr_ptr       <= '0;
      o_dict_count <= '0;
    end else if (push_en) begin
      valid[wr_ptr] <= 1'b1;
      wr_ptr        <= wr_ptr + IDX_W'(1);
      if (o_dict_count != FULL) o_dict_count <= o_dict_count + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_en) dict[wr_ptr] <= s1_word;
  end

endmodule
